spi_cmd_parser: RTL and testbench

- Consumes the byte stream from the SPI slave receiver: one strobe per received byte.
- Parses host write packets: opcode, 24-bit SNES address, 16-bit length, data bytes.
- Issues one cart-memory write per data byte over a req/ack handshake, with auto-incrementing address.
- Holds one byte in a skid register so the SPI side is never stalled during a write; reports status for the MISO path.

---
 rtl/spi_cmd_parser.sv | 160 ++++++++++++++++
 tb/tb_spi_cmd_parser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_parser.sv
// SPI host write-packet parser: opcode, address, length, then data bytes.
// Each data byte becomes one req/ack memory write; a skid byte absorbs stalls.
module spi_cmd_parser #(
    parameter int         ADDR_W   = 24,
    parameter int         LEN_W    = 16,
    parameter logic [7:0] OP_WRITE = 8'h01,
    parameter logic [7:0] OP_NOP   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              frame_rst,
    input  logic              clr_err,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_wr_ack,
    output logic              cmd_done,
    output logic              busy,
    output logic              err_opcode,
    output logic              err_overrun,
    output logic [7:0]        status
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR2    = 4'd1;
    localparam logic [3:0] S_ADDR1    = 4'd2;
    localparam logic [3:0] S_ADDR0    = 4'd3;
    localparam logic [3:0] S_LEN1     = 4'd4;
    localparam logic [3:0] S_LEN0     = 4'd5;
    localparam logic [3:0] S_DATA     = 4'd6;
    localparam logic [3:0] S_WAIT_ACK = 4'd7;
    localparam logic [3:0] S_DISCARD  = 4'd8;

    logic [3:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  len_next;
    logic [ADDR_W-1:0] addr_next;
    logic              skid_vld;
    logic [7:0]        skid_data;

    assign mem_addr  = addr;
    assign busy      = (state != S_IDLE);
    assign status    = {busy, 5'b0, err_overrun, err_opcode};
    assign len_next  = {remaining[LEN_W-9:0], rx_byte};
    assign addr_next = {addr[ADDR_W-9:0], rx_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            skid_vld    <= 1'b0;
            skid_data   <= 8'h00;
            mem_wr_req  <= 1'b0;
            mem_wdata   <= 8'h00;
            cmd_done    <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            // Set events below are later NBAs, so they win over a clear.
            if (clr_err) begin
                err_opcode  <= 1'b0;
                err_overrun <= 1'b0;
            end
            if (frame_rst) begin
                state      <= S_IDLE;
                mem_wr_req <= 1'b0;
                skid_vld   <= 1'b0;
                remaining  <= '0;
            end else begin
                unique case (state)
                    S_IDLE: if (rx_valid) begin
                        if (rx_byte == OP_WRITE) begin
                            state <= S_ADDR2;
                        end else if (rx_byte != OP_NOP) begin
                            err_opcode <= 1'b1;
                            state      <= S_DISCARD;
                        end
                    end
                    S_ADDR2: if (rx_valid) begin
                        addr  <= addr_next;
                        state <= S_ADDR1;
                    end
                    S_ADDR1: if (rx_valid) begin
                        addr  <= addr_next;
                        state <= S_ADDR0;
                    end
                    S_ADDR0: if (rx_valid) begin
                        addr  <= addr_next;
                        state <= S_LEN1;
                    end
                    S_LEN1: if (rx_valid) begin
                        remaining <= len_next;
                        state     <= S_LEN0;
                    end
                    S_LEN0: if (rx_valid) begin
                        remaining <= len_next;
                        if (len_next == '0) begin
                            cmd_done <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (skid_vld) begin
                            mem_wr_req <= 1'b1;
                            mem_wdata  <= skid_data;
                            skid_vld   <= rx_valid;
                            skid_data  <= rx_byte;
                            state      <= S_WAIT_ACK;
                        end else if (rx_valid) begin
                            mem_wr_req <= 1'b1;
                            mem_wdata  <= rx_byte;
                            state      <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (mem_wr_ack) begin
                            addr      <= addr + ADDR_W'(1);
                            remaining <= remaining - LEN_W'(1);
                            if (remaining == LEN_W'(1)) begin
                                mem_wr_req <= 1'b0;
                                cmd_done   <= 1'b1;
                                skid_vld   <= 1'b0;
                                state      <= S_IDLE;
                                // Bytes beyond the length field are lost.
                                if (skid_vld || rx_valid)
                                    err_overrun <= 1'b1;
                            end else if (skid_vld) begin
                                mem_wdata <= skid_data;
                                skid_vld  <= rx_valid;
                                skid_data <= rx_byte;
                            end else begin
                                mem_wr_req <= 1'b0;
                                skid_vld   <= rx_valid;
                                skid_data  <= rx_byte;
                                state      <= S_DATA;
                            end
                        end else if (rx_valid) begin
                            if (!skid_vld) begin
                                skid_vld  <= 1'b1;
                                skid_data <= rx_byte;
                            end else begin
                                err_overrun <= 1'b1;
                            end
                        end
                    end
                    S_DISCARD: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Directed bench for spi_cmd_parser with a packet-level write model.
// Expected writes are derived from packet contents and checked per cycle.
module tb_spi_cmd_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        frame_rst = 1'b0;
    logic        clr_err = 1'b0;
    logic        mem_wr_ack = 1'b0;
    logic        mem_wr_req;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cmd_done;
    logic        busy;
    logic        err_opcode;
    logic        err_overrun;
    logic [7:0]  status;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int ack_delay = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wr_log[$];
    logic [7:0]  data_q[$];
    logic [31:0] exp_w;

    spi_cmd_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .frame_rst  (frame_rst),
        .clr_err    (clr_err),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr_ack (mem_wr_ack),
        .cmd_done   (cmd_done),
        .busy       (busy),
        .err_opcode (err_opcode),
        .err_overrun(err_overrun),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every accepted write is checked against the packet model.
    always @(negedge clk) begin
        if (mem_wr_req && mem_wr_ack) begin
            wr_log.push_back({mem_wdata, mem_addr});
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %h expected none",
                         {mem_wdata, mem_addr});
            end else begin
                exp_w = exp_q.pop_front();
                chk("write", {mem_wdata, mem_addr}, exp_w);
            end
        end
        if (cmd_done) done_cnt++;
    end

    initial begin
        int wc;
        wc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_wr_req) begin
                if (wc >= ack_delay) begin
                    mem_wr_ack = 1'b1;
                    wc = 0;
                end else begin
                    mem_wr_ack = 1'b0;
                    wc++;
                end
            end else begin
                mem_wr_ack = 1'b0;
                wc = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frame_rst();
        frame_rst = 1'b1;
        idle(1);
        frame_rst = 1'b0;
    endtask

    task automatic pulse_clr_err();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
    endtask

    task automatic write_pkt(input logic [23:0] base,
                             input logic [15:0] len,
                             input bit track);
        logic [23:0] a;
        send(8'h01);
        send(base[23:16]);
        send(base[15:8]);
        send(base[7:0]);
        send(len[15:8]);
        send(len[7:0]);
        for (int i = 0; i < data_q.size(); i++) begin
            a = base + 24'(i);
            if (track && i < int'(len))
                exp_q.push_back({data_q[i], a});
            send(data_q[i]);
            if (i == 0) chk("latency_req", mem_wr_req, 1);
        end
    endtask

    task automatic wait_writes(input int n, input string name);
        int c;
        c = 0;
        while (wr_log.size() < n && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, wr_log.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_wr_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_status", status, 8'h00);
        rst_n = 1'b1;
        idle(1);

        ack_delay = 0;
        data_q.delete();
        data_q.push_back(8'hAA);
        data_q.push_back(8'hBB);
        data_q.push_back(8'hCC);
        write_pkt(24'h123456, 16'd3, 1'b1);
        wait_writes(3, "t1_writes");
        idle(2);
        chk("t1_done", done_cnt, 1);
        chk("t1_busy", busy, 0);
        chk("t1_w0", wr_log[0], {8'hAA, 24'h123456});
        chk("t1_w2", wr_log[2], {8'hCC, 24'h123458});

        data_q.delete();
        data_q.push_back(8'h11);
        data_q.push_back(8'h22);
        write_pkt(24'hFFFFFF, 16'd2, 1'b1);
        wait_writes(5, "t2_writes");
        idle(2);
        chk("t2_done", done_cnt, 2);
        chk("t2_w_top", wr_log[3], {8'h11, 24'hFFFFFF});
        chk("t2_w_wrap", wr_log[4], {8'h22, 24'h000000});

        ack_delay = 20;
        data_q.delete();
        write_pkt(24'h002000, 16'd3, 1'b1);
        exp_q.push_back({8'h5A, 24'h002000});
        exp_q.push_back({8'h6B, 24'h002001});
        send(8'h5A);
        idle(2);
        send(8'h6B);
        idle(1);
        send(8'h7C);
        idle(1);
        chk("t3_overrun", err_overrun, 1);
        chk("t3_status", status, 8'h82);
        chk("t3_req_held", mem_wr_req, 1);
        wait_writes(7, "t3_writes");
        idle(1);
        chk("t3_status_data", status, 8'h82);
        chk("t3_no_done", done_cnt, 2);
        pulse_frame_rst();
        chk("t3_fr_status", status, 8'h02);
        pulse_clr_err();
        chk("t3_clr_status", status, 8'h00);

        ack_delay = 0;
        send(8'h7E);
        chk("t4_status", status, 8'h81);
        send(8'h01);
        send(8'h12);
        send(8'h00);
        send(8'h01);
        send(8'hAA);
        idle(2);
        chk("t4_no_writes", wr_log.size(), 7);
        chk("t4_discard_busy", busy, 1);
        pulse_frame_rst();
        chk("t4_fr_busy", busy, 0);
        chk("t4_fr_err", err_opcode, 1);
        clr_err = 1'b1;
        send(8'h7E);
        clr_err = 1'b0;
        chk("t4_err_wins", err_opcode, 1);
        pulse_frame_rst();
        pulse_clr_err();
        chk("t4_clr_status", status, 8'h00);

        data_q.delete();
        write_pkt(24'h000010, 16'd0, 1'b1);
        chk("t5_done_pulse", cmd_done, 1);
        idle(1);
        chk("t5_done_low", cmd_done, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done_cnt", done_cnt, 3);
        chk("t5_no_writes", wr_log.size(), 7);

        ack_delay = 50;
        data_q.delete();
        data_q.push_back(8'h77);
        write_pkt(24'h003000, 16'd2, 1'b0);
        idle(3);
        chk("t6_req_wait", mem_wr_req, 1);
        pulse_frame_rst();
        chk("t6_fr_req", mem_wr_req, 0);
        chk("t6_fr_busy", busy, 0);
        chk("t6_fr_done", cmd_done, 0);
        idle(2);
        chk("t6_done_cnt", done_cnt, 3);

        data_q.delete();
        data_q.push_back(8'h99);
        write_pkt(24'h004000, 16'd2, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", mem_wr_req, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_wdata", mem_wdata, 0);
        chk("t6_rst_done", cmd_done, 0);
        chk("t6_rst_status", status, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        chk("t6_exp_empty", exp_q.size(), 0);
        chk("t6_log_size", wr_log.size(), 7);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
